// File: rtl/fifo_mc_pkg.sv
// fifo_mc_pkg: shared channel-width helper and per-channel status type for fifo_sync_mc
// Optional feature macro used across this slice: FIFO_MC_ERR_EN
package fifo_mc_pkg;
  localparam int LVL_W = 16;
  typedef struct packed {
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             full;
    logic             almost_full;
  } fifo_mc_status_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_sync_mc_if.sv
// fifo_sync_mc_if: push/pop/status bundle of fifo_sync_mc
// Ports: push/push_ch/w_data, pop/pop_ch/r_data, full/empty/almost_full/level;
// err_clr/ovf/udf exist only with FIFO_MC_ERR_EN. master drives requests, slave is the FIFO.
interface fifo_sync_mc_if import fifo_mc_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CW = cw(CHANNELS);
  localparam int AW = $clog2(DEPTH);
  logic                       push;
  logic [CW-1:0]              push_ch;
  logic [WIDTH-1:0]           w_data;
  logic                       pop;
  logic [CW-1:0]              pop_ch;
  logic [WIDTH-1:0]           r_data;
  logic [CHANNELS-1:0]        full;
  logic [CHANNELS-1:0]        empty;
  logic [CHANNELS-1:0]        almost_full;
  logic [CHANNELS*(AW+1)-1:0] level;
`ifdef FIFO_MC_ERR_EN
  logic                       err_clr;
  logic [CHANNELS-1:0]        ovf;
  logic [CHANNELS-1:0]        udf;
`endif
  modport master (
    output push, push_ch, w_data, pop, pop_ch,
    input  r_data, full, empty, almost_full, level
`ifdef FIFO_MC_ERR_EN
    , output err_clr, input ovf, udf
`endif
  );
  modport slave (
    input  push, push_ch, w_data, pop, pop_ch,
    output r_data, full, empty, almost_full, level
`ifdef FIFO_MC_ERR_EN
    , input err_clr, output ovf, udf
`endif
  );
endinterface

// File: rtl/fifo_mc_ctrl.sv
// fifo_mc_ctrl: one channel's pointers, level and registered flags
// Ports: clk, n_rst (sync, active-low), inc_w/inc_r accepted push/pop strobes,
// wptr/rptr, st status; err_clr/set_ovf/set_udf/ovf/udf with FIFO_MC_ERR_EN.
module fifo_mc_ctrl import fifo_mc_pkg::*; #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            inc_w,
  input  logic            inc_r,
`ifdef FIFO_MC_ERR_EN
  input  logic            err_clr,
  input  logic            set_ovf,
  input  logic            set_udf,
  output logic            ovf,
  output logic            udf,
`endif
  output logic [AW-1:0]   wptr,
  output logic [AW-1:0]   rptr,
  output fifo_mc_status_t st
);
  logic [AW:0] lvl, lvl_n;
  logic        empty, full, af;
  assign lvl_n = (inc_w && !inc_r) ? lvl + 1'b1 : (!inc_w && inc_r) ? lvl - 1'b1 : lvl;
  assign st = {LVL_W'(lvl), empty, full, af};
  // flags are registered from the next level so they line up with lvl
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      lvl   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      af    <= 1'b0;
    end else begin
      wptr  <= wptr + AW'(inc_w);
      rptr  <= rptr + AW'(inc_r);
      lvl   <= lvl_n;
      empty <= lvl_n == '0;
      full  <= lvl_n == (AW+1)'(DEPTH);
      af    <= lvl_n >= (AW+1)'(AF_THRESH);
    end
  end
`ifdef FIFO_MC_ERR_EN
  // clear has priority over a set in the same cycle
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= err_clr ? 1'b0 : ovf | set_ovf;
      udf <= err_clr ? 1'b0 : udf | set_udf;
    end
  end
`endif
endmodule

// File: rtl/fifo_sync_mc.sv
// fifo_sync_mc: single-clock multi-channel FIFO sharing one storage array addressed {channel, pointer}
// Ports: clk, n_rst (sync, active-low), bus (fifo_sync_mc_if.slave: push/pop requests,
// combinational r_data of pop_ch, per-channel full/empty/almost_full/level).
// FIFO_MC_ERR_EN adds sticky per-channel ovf/udf with err_clr.
module fifo_sync_mc import fifo_mc_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int AF_THRESH = DEPTH - 2
) (
  input logic           clk,
  input logic           n_rst,
  fifo_sync_mc_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cw(CHANNELS);
  logic [WIDTH-1:0] mem [(2**CW)*DEPTH];
  logic [AW-1:0]    wptr [CHANNELS];
  logic [AW-1:0]    rptr [CHANNELS];
  fifo_mc_status_t  st [CHANNELS];
  logic             push_ok, pop_ok;
`ifdef FIFO_MC_ERR_EN
  logic [CHANNELS-1:0] ovf_v, udf_v;
  assign bus.ovf = ovf_v;
  assign bus.udf = udf_v;
`endif
  assign push_ok    = n_rst && bus.push && !bus.full[bus.push_ch];
  assign pop_ok     = n_rst && bus.pop && !bus.empty[bus.pop_ch];
  assign bus.r_data = mem[{bus.pop_ch, rptr[bus.pop_ch]}];
  always_ff @(posedge clk)
    if (push_ok) mem[{bus.push_ch, wptr[bus.push_ch]}] <= bus.w_data;
  always_comb begin
    bus.full        = '0;
    bus.empty       = '0;
    bus.almost_full = '0;
    bus.level       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.full[c]               = st[c].full;
      bus.empty[c]              = st[c].empty;
      bus.almost_full[c]        = st[c].almost_full;
      bus.level[c*(AW+1) +: AW+1] = st[c].level[AW:0];
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic inc_w, inc_r;
    assign inc_w = push_ok && bus.push_ch == CW'(c);
    assign inc_r = pop_ok && bus.pop_ch == CW'(c);
    fifo_mc_ctrl #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_ctrl (
      .clk     (clk),
      .n_rst   (n_rst),
      .inc_w   (inc_w),
      .inc_r   (inc_r),
`ifdef FIFO_MC_ERR_EN
      .err_clr (bus.err_clr),
      .set_ovf (bus.push && bus.push_ch == CW'(c) && st[c].full),
      .set_udf (bus.pop && bus.pop_ch == CW'(c) && st[c].empty),
      .ovf     (ovf_v[c]),
      .udf     (udf_v[c]),
`endif
      .wptr    (wptr[c]),
      .rptr    (rptr[c]),
      .st      (st[c])
    );
  end
endmodule
